psd_sqrt_gen: RTL and testbench
===============================

Name: psd_sqrt_gen

Overview:
- Parametrised sequential integer square root: digit-by-digit, one result bit per clock, no multiplier.
- Operand width, fractional precision and rounding mode are generalised.
- Adds a start/busy/done handshake, a selectable rounding mode, saturation on rounding overflow, and a fixed-point result output.
- Sits as a shared arithmetic unit behind a controller that issues one operand at a time and waits for done.

Parameters:
- NBITSIN, 32, operand width; even, 4..62.
- NFRAC, 4, number of fractional result bits computed; 1..16.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous reset, active high
- start  in  1  one-cycle request; accepted only when busy=0
- rmode  in  2  rounding mode, sampled with start: 00 floor, 01 nearest, 10 ceiling, 11 treated as floor
- xin  in  NBITSIN  unsigned integer operand, sampled with start
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse when results are updated
- sqrt  out  NBITSIN/2  rounded integer square root
- sqrt_fx  out  NBITSIN/2+NFRAC  truncated fixed-point root, unsigned, NFRAC fractional bits
- sat  out  1  rounding overflowed and sqrt is saturated

Behaviour:
- Reset: asynchronous, active high. Clears busy, done, sqrt, sqrt_fx and sat to 0, and returns the FSM to IDLE. Reset mid-operation aborts the operation; no done is produced.
- Let W = NBITSIN/2 + NFRAC. Internal operand X = xin * 4^NFRAC, which is NBITSIN + 2*NFRAC bits.
- FSM states: IDLE, CALC, ROUND.
  - IDLE: if start=1 at a rising edge, latch X and rmode, clear the partial root and remainder, load iteration count W-1, and go to CALC. busy=1 from the next cycle.
  - CALC: one iteration per cycle, MSB first, using a restoring trial subtract on remainder/partial-root registers. Go to ROUND after W iterations.
  - ROUND: one cycle. On the closing edge, register sqrt, sqrt_fx and sat, pulse done=1 for exactly one cycle, set busy=0, and return to IDLE.
- Latency: start sampled at edge t; done=1 and outputs valid in the cycle following edge t+W+1. Defaults give 21 cycles.
- start while busy=1: ignored; in-flight operation unaffected.
- start in the same cycle that done=1: accepted (the FSM is IDLE).
- sqrt, sqrt_fx and sat hold their values until the next done or reset.
- Let q = W-bit truncated root, I = integer field, F = fraction field, R = final remainder.
  - sqrt_fx = q.
  - Floor: sqrt = I.
  - Nearest: sqrt = I + F[NFRAC-1]. Exact half ties are arithmetically impossible for integer operands, so no tie rule is applied.
  - Ceiling: sqrt = I + 1 if F != 0 or R != 0, else I.
- Increment carry-out (I all-ones): sqrt = all-ones and sat = 1; otherwise sat = 0.

Optional Feature:
- Macro SQRT_REMAINDER_EN.
- Defined: adds output port rem, width W+1, giving R = X - q*q. Registered on the same edge as sqrt, reset to 0.
- Undefined: the port is absent. R is still used internally for ceiling mode.
- All other behaviour is identical in both cases.

Test Plan:
- Defaults, xin=0, rmode=00: sqrt=0, sqrt_fx=0, sat=0. done exactly 21 cycles after the start edge; busy high for 21 cycles.
- xin=2, all three modes: sqrt_fx=0x16 (1.0110b) in every mode; sqrt = 1 (floor), 1 (nearest), 2 (ceiling). With SQRT_REMAINDER_EN, rem=28.
- xin=6 -> sqrt_fx=0x27, sqrt = 2/2/3 for floor/nearest/ceiling. xin=7 -> sqrt_fx=0x2A, nearest=3. xin=16 -> sqrt=4 in all modes, sqrt_fx=0x40.
- xin=0xFFFFFFFF: floor gives sqrt=0xFFFF, sat=0. Nearest and ceiling give sqrt=0xFFFF, sat=1, with sqrt_fx=0xFFFFF.
- start pulsed again at cycle 5 of an operation with a different xin: ignored, first result unchanged. Back-to-back start on the done cycle: accepted, second done 21 cycles later.
- reset asserted asynchronously mid-CALC: outputs 0 immediately, no done pulse. A fresh start afterwards completes normally.
- Parameter sweep NBITSIN = 4/16/62 and NFRAC = 1/8, random operands: sqrt_fx == floor(sqrt(xin * 4^NFRAC)) and rounding matches the reference model.

Source files
------------

// File: rtl/psd_sqrt_gen_if.sv
// Purpose: request/result bundle for the sequential square-root unit.
// Ports: start/rmode/xin issued by the controller (master); busy/done and
//        the registered results sqrt/sqrt_fx/sat (plus rem when
//        SQRT_REMAINDER_EN is defined) returned by the unit (slave).
interface psd_sqrt_gen_if #(
    parameter int NBITSIN = 32,
    parameter int NFRAC   = 4
);
    logic                         start;
    logic [1:0]                   rmode;
    logic [NBITSIN-1:0]           xin;
    logic                         busy;
    logic                         done;
    logic [NBITSIN/2-1:0]         sqrt;
    logic [NBITSIN/2+NFRAC-1:0]   sqrt_fx;
    logic                         sat;
`ifdef SQRT_REMAINDER_EN
    logic [NBITSIN/2+NFRAC:0]     rem;

    modport master (output start, rmode, xin,
                    input  busy, done, sqrt, sqrt_fx, sat, rem);
    modport slave  (input  start, rmode, xin,
                    output busy, done, sqrt, sqrt_fx, sat, rem);
`else
    modport master (output start, rmode, xin,
                    input  busy, done, sqrt, sqrt_fx, sat);
    modport slave  (input  start, rmode, xin,
                    output busy, done, sqrt, sqrt_fx, sat);
`endif
endinterface

// File: rtl/psd_sqrt_gen.sv
// Purpose: digit-by-digit (restoring) unsigned square root, one result bit
//          per clock, with floor/nearest/ceiling rounding and saturation.
// Ports: clock, reset (async, active high); bus (slave modport) carries
//        start/rmode/xin in and busy/done/sqrt/sqrt_fx/sat out.
// Latency: start at edge t -> done pulse after edge t+W+1, W=NBITSIN/2+NFRAC.
// Busy behaviour: start is ignored while busy=1; accepted on the done cycle.
// Optional: define SQRT_REMAINDER_EN to add bus.rem = X - sqrt_fx^2.
module psd_sqrt_gen #(
    parameter int NBITSIN = 32,
    parameter int NFRAC   = 4
) (
    input  logic clock,
    input  logic reset,
    psd_sqrt_gen_if.slave bus
);
    localparam int HALF = NBITSIN / 2;
    localparam int W    = HALF + NFRAC;   // root bits computed
    localparam int NX   = 2 * W;          // xin * 4^NFRAC
    localparam int RW   = W + 1;          // final remainder <= 2q fits here
    localparam int CW   = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;
    state_t state, state_nxt;

    logic [NX-1:0] x_sh;      // operand, consumed two bits per cycle from the top
    logic [W-1:0]  root;
    logic [RW-1:0] rem_r;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_r;

    logic [HALF-1:0]    sqrt_r;
    logic [W-1:0]       sqrt_fx_r;
    logic               sat_r;
    logic               done_r;

    // ---- next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---- one restoring iteration ----
    logic [W+2:0] trial_in;   // remainder with next operand digit pair appended
    logic [W+2:0] trial_sub;  // 4*root + 1
    logic [W+2:0] trial_diff;
    logic         trial_ge;

    always_comb begin
        trial_in   = {rem_r, x_sh[NX-1:NX-2]};
        trial_sub  = {1'b0, root, 2'b01};
        trial_diff = trial_in - trial_sub;
        trial_ge   = (trial_in >= trial_sub);
    end

    // ---- rounding of the truncated root ----
    logic [HALF-1:0]  int_f;
    logic [NFRAC-1:0] frac_f;
    logic             inc;
    logic             sat_nxt;
    logic [HALF-1:0]  sqrt_nxt;

    always_comb begin
        int_f  = root[W-1:NFRAC];
        frac_f = root[NFRAC-1:0];
        inc    = 1'b0;
        case (mode_r)
            2'b01:   inc = frac_f[NFRAC-1];
            // any discarded fraction or nonzero remainder means inexact
            2'b10:   inc = (|frac_f) | (|rem_r);
            default: inc = 1'b0;
        endcase
        sat_nxt  = inc & (&int_f);
        sqrt_nxt = sat_nxt ? {HALF{1'b1}} : (int_f + {{(HALF-1){1'b0}}, inc});
    end

    // ---- datapath ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_sh      <= '0;
            root      <= '0;
            rem_r     <= '0;
            cnt       <= '0;
            mode_r    <= 2'b00;
            sqrt_r    <= '0;
            sqrt_fx_r <= '0;
            sat_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_sh   <= {bus.xin, {(2*NFRAC){1'b0}}};
                        mode_r <= bus.rmode;
                        root   <= '0;
                        rem_r  <= '0;
                        cnt    <= CW'(W - 1);
                    end
                end
                CALC: begin
                    x_sh  <= {x_sh[NX-3:0], 2'b00};
                    root  <= {root[W-2:0], trial_ge};
                    rem_r <= trial_ge ? trial_diff[RW-1:0] : trial_in[RW-1:0];
                    cnt   <= cnt - 1'b1;
                end
                ROUND: begin
                    sqrt_r    <= sqrt_nxt;
                    sqrt_fx_r <= root;
                    sat_r     <= sat_nxt;
                    done_r    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SQRT_REMAINDER_EN
    logic [RW-1:0] rem_out;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              rem_out <= '0;
        else if (state == ROUND) rem_out <= rem_r;
    end
    assign bus.rem = rem_out;
`endif

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.sqrt    = sqrt_r;
    assign bus.sqrt_fx = sqrt_fx_r;
    assign bus.sat     = sat_r;
endmodule

// File: tb/tb_psd_sqrt_gen.sv
// Directed testbench for psd_sqrt_gen: default configuration plus two
// extra instances (NBITSIN=4/NFRAC=1 and NBITSIN=62/NFRAC=8) checked
// against an independent integer square-root reference.
module tb_psd_sqrt_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    psd_sqrt_gen_if #(.NBITSIN(32), .NFRAC(4)) bus ();
    psd_sqrt_gen_if #(.NBITSIN(4),  .NFRAC(1)) bus_a ();
    psd_sqrt_gen_if #(.NBITSIN(62), .NFRAC(8)) bus_b ();

    psd_sqrt_gen #(.NBITSIN(32), .NFRAC(4)) dut   (.clock(clock), .reset(reset), .bus(bus));
    psd_sqrt_gen #(.NBITSIN(4),  .NFRAC(1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    psd_sqrt_gen #(.NBITSIN(62), .NFRAC(8)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    // floor(sqrt(x)) by bit search on squares
    function automatic logic [127:0] isqrt(input logic [127:0] x);
        logic [127:0] r, t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    // returns {sat, sqrt}
    function automatic logic [64:0] ref_round(input logic [127:0] q, input logic [127:0] r,
                                              input logic [1:0] m, input int half, input int nfrac);
        logic [127:0] i_f, f_f, max_i;
        logic inc;
        i_f   = q >> nfrac;
        f_f   = q & ((128'd1 << nfrac) - 1);
        max_i = (128'd1 << half) - 1;
        inc   = 1'b0;
        if (m == 2'b01) inc = f_f[nfrac-1];
        if (m == 2'b10) inc = (f_f != 0) || (r != 0);
        if (inc && i_f == max_i) return {1'b1, max_i[63:0]};
        i_f = i_f + {127'd0, inc};
        return {1'b0, i_f[63:0]};
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [1:0] m, output int lat, output int busy_cnt);
        @(negedge clock);
        bus.start = 1'b1; bus.xin = x; bus.rmode = m;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (lat < 60 && bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sqrt !== 16'd0 ||
            bus.sqrt_fx !== 20'd0 || bus.sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b sqrt=%h fx=%h sat=%b, required all 0",
                     bus.busy, bus.done, bus.sqrt, bus.sqrt_fx, bus.sat);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_zero;
        int lat, bc;
        run_op(32'd0, 2'b00, lat, bc);
        checks++;
        if (lat !== 21) begin failures++; $display("FAIL zero_latency: got %0d required 21", lat); end
        checks++;
        if (bc !== 21) begin failures++; $display("FAIL zero_busy_cycles: got %0d required 21", bc); end
        checks++;
        if (bus.sqrt !== 16'd0 || bus.sqrt_fx !== 20'd0 || bus.sat !== 1'b0) begin
            failures++;
            $display("FAIL zero_result: sqrt=%h fx=%h sat=%b required 0/0/0", bus.sqrt, bus.sqrt_fx, bus.sat);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sqrt !== 16'd0) begin
            failures++;
            $display("FAIL done_one_cycle: done=%b sqrt=%h required done=0 sqrt=0", bus.done, bus.sqrt);
        end
    endtask

    task automatic test_modes;
        logic [31:0] xs [12] = '{2, 2, 2, 6, 6, 6, 7, 16, 16, 16, 16, 7};
        logic [1:0]  ms [12] = '{0, 1, 2, 0, 1, 2, 1, 0, 1, 2, 3, 3};
        logic [15:0] es [12] = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 4, 4, 2};
        logic [19:0] ef [12] = '{20'h16, 20'h16, 20'h16, 20'h27, 20'h27, 20'h27,
                                 20'h2A, 20'h40, 20'h40, 20'h40, 20'h40, 20'h2A};
        logic [20:0] er [12] = '{28, 28, 28, 15, 15, 15, 28, 0, 0, 0, 0, 28};
        int lat, bc;
        for (int i = 0; i < 12; i++) begin
            run_op(xs[i], ms[i], lat, bc);
            checks++;
            if (lat !== 21 || bus.sqrt !== es[i] || bus.sqrt_fx !== ef[i] || bus.sat !== 1'b0) begin
                failures++;
                $display("FAIL modes[%0d] x=%0d m=%0d: lat=%0d sqrt=%h fx=%h sat=%b required lat=21 sqrt=%h fx=%h sat=0",
                         i, xs[i], ms[i], lat, bus.sqrt, bus.sqrt_fx, bus.sat, es[i], ef[i]);
            end
`ifdef SQRT_REMAINDER_EN
            checks++;
            if (bus.rem !== er[i]) begin
                failures++;
                $display("FAIL rem[%0d]: got %0d required %0d", i, bus.rem, er[i]);
            end
`else
            if (er[i] > 21'd28) $display("note: unexpected table entry %0d", i);
`endif
        end
    endtask

    task automatic test_saturation;
        logic [15:0] es [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic        et [3] = '{1'b0, 1'b1, 1'b1};
        int lat, bc;
        for (int m = 0; m < 3; m++) begin
            run_op(32'hFFFF_FFFF, 2'(m), lat, bc);
            checks++;
            if (bus.sqrt !== es[m] || bus.sat !== et[m] || bus.sqrt_fx !== 20'hFFFFF) begin
                failures++;
                $display("FAIL saturation m=%0d: sqrt=%h sat=%b fx=%h required sqrt=%h sat=%b fx=fffff",
                         m, bus.sqrt, bus.sat, bus.sqrt_fx, es[m], et[m]);
            end
`ifdef SQRT_REMAINDER_EN
            checks++;
            if (bus.rem !== 21'd2096895) begin
                failures++;
                $display("FAIL saturation_rem: got %0d required 2096895", bus.rem);
            end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clock);
        bus.start = 1'b1; bus.xin = 32'd6; bus.rmode = 2'b10;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock);
        bus.start = 1'b1; bus.xin = 32'd16; bus.rmode = 2'b00;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat = 5;
        while (lat < 60 && bus.done !== 1'b1) begin @(posedge clock); #1; lat++; end
        checks++;
        if (lat !== 21 || bus.sqrt !== 16'd3 || bus.sqrt_fx !== 20'h27) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d sqrt=%h fx=%h required lat=21 sqrt=3 fx=27",
                     lat, bus.sqrt, bus.sqrt_fx);
        end
        // the FSM must have returned to idle rather than restarting on the ignored pulse
        repeat (3) begin @(posedge clock); #1; end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_idle: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        run_op(32'd7, 2'b01, lat, bc);
        checks++;
        if (bus.done !== 1'b1 || bus.sqrt !== 16'd3) begin
            failures++;
            $display("FAIL b2b_first: done=%b sqrt=%h required 1/3", bus.done, bus.sqrt);
        end
        run_op(32'd16, 2'b00, lat, bc);   // start issued in the done cycle
        checks++;
        if (lat !== 21 || bus.sqrt !== 16'd4 || bus.sqrt_fx !== 20'h40) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d sqrt=%h fx=%h required 21/4/40", lat, bus.sqrt, bus.sqrt_fx);
        end
    endtask

    task automatic test_async_reset;
        int lat, bc, seen;
        run_op(32'd6, 2'b10, lat, bc);     // leaves sqrt=3 so reset has something to clear
        @(negedge clock);
        bus.start = 1'b1; bus.xin = 32'd7; bus.rmode = 2'b01;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (8) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sqrt !== 16'd0 ||
            bus.sqrt_fx !== 20'd0 || bus.sat !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b sqrt=%h fx=%h sat=%b required all 0",
                     bus.busy, bus.done, bus.sqrt, bus.sqrt_fx, bus.sat);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin @(posedge clock); #1; if (bus.done === 1'b1) seen++; end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL aborted_done: saw %0d pulses required 0", seen); end
        run_op(32'd16, 2'b01, lat, bc);
        checks++;
        if (lat !== 21 || bus.sqrt !== 16'd4) begin
            failures++;
            $display("FAIL after_reset: lat=%0d sqrt=%h required 21/4", lat, bus.sqrt);
        end
    endtask

    task automatic test_sweep_small;
        logic [127:0] xx, q, r;
        logic [64:0]  e;
        int lat;
        for (int x = 0; x < 16; x++) begin
            for (int m = 0; m < 4; m++) begin
                xx = 128'(x) << 2;
                q  = isqrt(xx);
                r  = xx - q * q;
                e  = ref_round(q, r, 2'(m), 2, 1);
                @(negedge clock);
                bus_a.start = 1'b1; bus_a.xin = 4'(x); bus_a.rmode = 2'(m);
                @(posedge clock); #1;
                bus_a.start = 1'b0;
                lat = 0;
                while (lat < 40 && bus_a.done !== 1'b1) begin @(posedge clock); #1; lat++; end
                checks++;
                if (lat !== 4 || bus_a.sqrt_fx !== q[2:0] || bus_a.sqrt !== e[1:0] || bus_a.sat !== e[64]) begin
                    failures++;
                    $display("FAIL sweep4 x=%0d m=%0d: lat=%0d fx=%h sqrt=%h sat=%b required lat=4 fx=%h sqrt=%h sat=%b",
                             x, m, lat, bus_a.sqrt_fx, bus_a.sqrt, bus_a.sat, q[2:0], e[1:0], e[64]);
                end
            end
        end
    endtask

    task automatic test_sweep_wide;
        logic [63:0]  rnd;
        logic [61:0]  xv;
        logic [127:0] xx, q, r;
        logic [64:0]  e;
        int lat;
        for (int i = 0; i < 12; i++) begin
            rnd = {$urandom(), $urandom()};
            xv  = (i == 0) ? {62{1'b1}} : rnd[61:0];
            for (int m = 0; m < 3; m++) begin
                xx = {66'd0, xv} << 16;
                q  = isqrt(xx);
                r  = xx - q * q;
                e  = ref_round(q, r, 2'(m), 31, 8);
                @(negedge clock);
                bus_b.start = 1'b1; bus_b.xin = xv; bus_b.rmode = 2'(m);
                @(posedge clock); #1;
                bus_b.start = 1'b0;
                lat = 0;
                while (lat < 80 && bus_b.done !== 1'b1) begin @(posedge clock); #1; lat++; end
                checks++;
                if (lat !== 40 || bus_b.sqrt_fx !== q[38:0] || bus_b.sqrt !== e[30:0] || bus_b.sat !== e[64]) begin
                    failures++;
                    $display("FAIL sweep62 x=%h m=%0d: lat=%0d fx=%h sqrt=%h sat=%b required lat=40 fx=%h sqrt=%h sat=%b",
                             xv, m, lat, bus_b.sqrt_fx, bus_b.sqrt, bus_b.sat, q[38:0], e[30:0], e[64]);
                end
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0; bus.xin   = '0; bus.rmode   = 2'b00;
        bus_a.start = 1'b0; bus_a.xin = '0; bus_a.rmode = 2'b00;
        bus_b.start = 1'b0; bus_b.xin = '0; bus_b.rmode = 2'b00;
        test_reset();
        test_zero();
        test_modes();
        test_saturation();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_sweep_small();
        test_sweep_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
